// File: rtl/frame_dump_pkg.sv
// Shared types for the frame dump trigger: FSM state encoding and frame counter width.
package frame_dump_pkg;

    localparam int unsigned FRAME_W = 32;

    typedef logic [FRAME_W-1:0] frame_cnt_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/frame_dump_edge.sv
// Falling-edge detector with optional 2-flop synchronizer; the fall pulse is registered.
module frame_dump_edge #(
    parameter bit SYNC = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic fall
);

    logic stage;
    logic hist;

    generate
        if (SYNC) begin : g_sync
            logic [1:0] sync;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync <= 2'b00;
                end else begin
                    sync <= {sync[0], din};
                end
            end
            assign stage = sync[1];
        end else begin : g_direct
            assign stage = din;
        end
    endgenerate

    // History resets low so a line already low at reset release never reads as a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 1'b0;
            fall <= 1'b0;
        end else begin
            hist <= stage;
            fall <= hist & ~stage;
        end
    end

endmodule

// File: rtl/frame_dump_trigger.sv
// Counts frames on VS falling edges and opens a FRAME_LEN-frame capture window at START_FRAME.
module frame_dump_trigger
    import frame_dump_pkg::*;
#(
    parameter int unsigned START_FRAME = 0,
    parameter int unsigned FRAME_LEN   = 0,
    parameter bit          WAIT_DL     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vs,
    input  logic       downloading,
    output frame_cnt_t frame_cnt,
    output logic       armed,
    output logic       dump_on,
    output logic       dump_start,
    output logic       dump_stop
);

    localparam frame_cnt_t START_CNT = frame_cnt_t'(START_FRAME);
    localparam frame_cnt_t WIN_LAST  = frame_cnt_t'(FRAME_LEN - 1);
    localparam bit         LEN_INF   = (FRAME_LEN == 0);
    localparam state_t     RST_STATE = WAIT_DL ? IDLE : ARMED;

    logic       vs_fall;
    logic       dl_fall;
    logic       vs_ok;
    logic       dl_ok;
    state_t     state;
    state_t     state_next;
    frame_cnt_t win_cnt;
    frame_cnt_t win_next;
    frame_cnt_t cnt_next;
    logic       armed_next;
    logic       dump_on_next;
    logic       dump_start_next;
    logic       dump_stop_next;

    frame_dump_edge #(.SYNC(1'b1)) u_vs_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (vs),
        .fall  (vs_fall)
    );

    frame_dump_edge #(.SYNC(1'b0)) u_dl_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (downloading),
        .fall  (dl_fall)
    );

    // Frames are ignored while a download is running; a download end restarts everything.
    assign vs_ok = vs_fall & ~(WAIT_DL & downloading);
    assign dl_ok = dl_fall & WAIT_DL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = frame_cnt;
        win_next   = win_cnt;
        if (dl_ok) begin
            state_next = ARMED;
            cnt_next   = '0;
            win_next   = '0;
        end else if (vs_ok) begin
            unique case (state)
                IDLE: ;
                ARMED: begin
                    cnt_next = frame_cnt + FRAME_W'(1);
                    if (frame_cnt == START_CNT) begin
                        state_next = ACTIVE;
                        win_next   = '0;
                    end
                end
                ACTIVE: begin
                    cnt_next = frame_cnt + FRAME_W'(1);
                    if (!LEN_INF && (win_cnt == WIN_LAST)) begin
                        state_next = DONE;
                    end else begin
                        win_next = win_cnt + FRAME_W'(1);
                    end
                end
                DONE: begin
                    cnt_next = frame_cnt + FRAME_W'(1);
                end
            endcase
        end
    end

    // Pulses come from the transition itself, so a restart out of ACTIVE never signals a stop.
    always_comb begin
        armed_next      = (state_next == ARMED);
        dump_on_next    = (state_next == ACTIVE);
        dump_start_next = (state == ARMED) && (state_next == ACTIVE);
        dump_stop_next  = (state == ACTIVE) && (state_next == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt  <= '0;
            win_cnt    <= '0;
            armed      <= ~WAIT_DL;
            dump_on    <= 1'b0;
            dump_start <= 1'b0;
            dump_stop  <= 1'b0;
        end else begin
            frame_cnt  <= cnt_next;
            win_cnt    <= win_next;
            armed      <= armed_next;
            dump_on    <= dump_on_next;
            dump_start <= dump_start_next;
            dump_stop  <= dump_stop_next;
        end
    end

endmodule

// File: tb/tb_frame_dump_trigger.sv
// Self-checking bench for frame_dump_trigger: table-driven VS frames plus hand-written corner sequences.
module tb_frame_dump_trigger;
    import frame_dump_pkg::*;

    typedef struct packed {
        logic [31:0] cnt;
        logic        armed;
        logic        on;
        logic        start;
        logic        stop;
    } obs_t;

    typedef struct {
        logic dl;
        obs_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vs;
    logic       downloading;
    logic       sel;
    frame_cnt_t cnt_a, cnt_b;
    logic       armed_a, on_a, start_a, stop_a;
    logic       armed_b, on_b, start_b, stop_b;

    vec_t tbl [11];
    obs_t sb_q [$];
    int   n_cmp = 0;
    int   n_err = 0;

    frame_dump_trigger #(.START_FRAME(3), .FRAME_LEN(2), .WAIT_DL(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading),
        .frame_cnt(cnt_a), .armed(armed_a), .dump_on(on_a),
        .dump_start(start_a), .dump_stop(stop_a)
    );

    frame_dump_trigger #(.START_FRAME(0), .FRAME_LEN(0), .WAIT_DL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading),
        .frame_cnt(cnt_b), .armed(armed_b), .dump_on(on_b),
        .dump_start(start_b), .dump_stop(stop_b)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        if (sel) o = '{cnt: cnt_b, armed: armed_b, on: on_b, start: start_b, stop: stop_b};
        else     o = '{cnt: cnt_a, armed: armed_a, on: on_a, start: start_a, stop: stop_a};
        return o;
    endfunction

    function automatic obs_t mk(input logic [31:0] c, input logic a, input logic o,
                                input logic s, input logic p);
        obs_t r;
        r = '{cnt: c, armed: a, on: o, start: s, stop: p};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_obs(input string tag, input obs_t act, input obs_t exp);
        chk({tag, ".frame_cnt"},  act.cnt,          exp.cnt);
        chk({tag, ".armed"},      32'(act.armed),   32'(exp.armed));
        chk({tag, ".dump_on"},    32'(act.on),      32'(exp.on));
        chk({tag, ".dump_start"}, 32'(act.start),   32'(exp.start));
        chk({tag, ".dump_stop"},  32'(act.stop),    32'(exp.stop));
    endtask

    // One VS frame: drop vs, wait (bounded) for the count to move, compare against the scoreboard.
    task automatic vs_frame(input string tag);
        obs_t       act;
        obs_t       exp;
        frame_cnt_t prev;
        act  = observe();
        prev = act.cnt;
        @(negedge clk);
        vs = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            act = observe();
            if (act.cnt !== prev) break;
        end
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s.scoreboard: got empty queue expected an entry", tag);
        end else begin
            exp = sb_q.pop_front();
            chk_obs(tag, act, exp);
        end
        @(negedge clk);
        vs = 1'b1;
        @(posedge clk);
        #1;
        act = observe();
        chk({tag, ".start_width"}, 32'(act.start), 32'd0);
        chk({tag, ".stop_width"},  32'(act.stop),  32'd0);
        repeat (3) @(posedge clk);
    endtask

    task automatic run_rows(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            downloading = tbl[i].dl;
            sb_q.push_back(tbl[i].exp);
            vs_frame($sformatf("%s[%0d]", tag, i));
        end
    endtask

    initial begin
        obs_t act;
        logic stop_seen;

        tbl[0]  = '{dl: 1'b1, exp: mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[1]  = '{dl: 1'b1, exp: mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[2]  = '{dl: 1'b1, exp: mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[3]  = '{dl: 1'b0, exp: mk(32'd1, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[4]  = '{dl: 1'b0, exp: mk(32'd2, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[5]  = '{dl: 1'b0, exp: mk(32'd3, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[6]  = '{dl: 1'b0, exp: mk(32'd4, 1'b0, 1'b1, 1'b1, 1'b0)};
        tbl[7]  = '{dl: 1'b0, exp: mk(32'd5, 1'b0, 1'b1, 1'b0, 1'b0)};
        tbl[8]  = '{dl: 1'b0, exp: mk(32'd6, 1'b0, 1'b0, 1'b0, 1'b1)};
        tbl[9]  = '{dl: 1'b0, exp: mk(32'd7, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[10] = '{dl: 1'b0, exp: mk(32'd8, 1'b0, 1'b0, 1'b0, 1'b0)};

        sel         = 1'b0;
        rst_n       = 1'b0;
        vs          = 1'b1;
        downloading = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_obs("reset_a", observe(), mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("reset_b.armed", 32'(armed_b), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // VS frames during download are ignored.
        run_rows(0, 2, "dl_ignore");

        // Download end arms two clocks later.
        @(negedge clk);
        downloading = 1'b0;
        @(posedge clk); #1;
        chk("dl_fall.armed_early", 32'(armed_a), 32'd0);
        @(posedge clk); #1;
        chk("dl_fall.armed", 32'(armed_a), 32'd1);
        chk("dl_fall.frame_cnt", cnt_a, 32'd0);

        run_rows(3, 10, "window");

        // Wrap in DONE: count rolls to zero, state stays DONE.
        @(negedge clk);
        force dut_a.frame_cnt = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut_a.frame_cnt;
        @(posedge clk); #1;
        chk("wrap.preload", cnt_a, 32'hFFFF_FFFF);
        sb_q.push_back(mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        vs_frame("wrap");

        // New download end out of DONE restarts the count.
        @(negedge clk);
        downloading = 1'b1;
        repeat (2) @(negedge clk);
        downloading = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_obs("rearm", observe(), mk(32'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        run_rows(3, 6, "reopen");

        // Download end coincident with a VS fall while ACTIVE.
        @(negedge clk);
        downloading = 1'b1;
        repeat (2) @(negedge clk);
        vs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        downloading = 1'b0;
        @(posedge clk); #1;
        chk("coinc.still_on", 32'(on_a), 32'd1);
        @(posedge clk); #1;
        chk_obs("coinc", observe(), mk(32'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        vs = 1'b1;
        stop_seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (stop_a) stop_seen = 1'b1;
        end
        chk("coinc.no_stop", 32'(stop_seen), 32'd0);
        chk("coinc.vs_discarded", cnt_a, 32'd0);

        // Asynchronous reset in the middle of a window.
        run_rows(3, 6, "reopen2");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_obs("async_rst_a", observe(), mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("async_rst_b.armed", 32'(armed_b), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        sel   = 1'b1;
        repeat (4) @(posedge clk);

        // Armed out of reset, window opens on first frame and never closes.
        sb_q.push_back(mk(32'd1, 1'b0, 1'b1, 1'b1, 1'b0));
        vs_frame("open_inf");
        for (int i = 0; i < 100; i++) begin
            sb_q.push_back(mk(32'(i + 2), 1'b0, 1'b1, 1'b0, 1'b0));
            vs_frame($sformatf("inf[%0d]", i));
        end
        chk("inf.queue_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
